// File: rtl/regbank_pkg.sv
//------------------------------------------------------------------------------
// Module   : regbank_pkg
// Brief    : Shared widths and word type for the execute-stage register bank.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package regbank_pkg;
    localparam int BUS     = 32;
    localparam int DIR     = 4;
    localparam int REG_NUM = 2 ** DIR;

    typedef logic [BUS-1:0] word_t;
endpackage

`default_nettype wire

// File: rtl/regbank_storage.sv
//------------------------------------------------------------------------------
// Module   : regbank_storage
// Brief    : reg_num x bus register array, one write port, four async reads.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regbank_storage
    import regbank_pkg::*;
#(
    parameter int bus     = BUS,
    parameter int dir     = DIR,
    parameter int reg_num = REG_NUM
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_we,
    input  logic [dir-1:0] i_wa,
    input  logic [bus-1:0] i_wd,
    input  logic [dir-1:0] i_ra0,
    input  logic [dir-1:0] i_ra1,
    input  logic [dir-1:0] i_ra2,
    input  logic [dir-1:0] i_ra3,
    output logic [bus-1:0] o_rd0,
    output logic [bus-1:0] o_rd1,
    output logic [bus-1:0] o_rd2,
    output logic [bus-1:0] o_rd3
);

    logic [bus-1:0] r_mem_q [reg_num];
    logic [bus-1:0] w_mem_d [reg_num];

    always_comb begin
        w_mem_d = r_mem_q;
        if (i_we) begin
            w_mem_d[i_wa] = i_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < reg_num; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_mem_q <= w_mem_d;
        end
    end

    // Reads see the stored (pre-write) contents; bypassing is done by the caller.
    assign o_rd0 = r_mem_q[i_ra0];
    assign o_rd1 = r_mem_q[i_ra1];
    assign o_rd2 = r_mem_q[i_ra2];
    assign o_rd3 = r_mem_q[i_ra3];

endmodule

`default_nettype wire

// File: rtl/register_bank.sv
//------------------------------------------------------------------------------
// Module   : register_bank
// Brief    : 16x32 register file with registered read ports and PC pipe stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module register_bank
    import regbank_pkg::*;
#(
    parameter int bus     = BUS,
    parameter int dir     = DIR,
    parameter int reg_num = REG_NUM
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [dir-1:0] RD,
    input  logic [dir-1:0] RS,
    input  logic [dir-1:0] RX,
    input  logic [dir-1:0] RK,
    input  logic [bus-1:0] WB,
    input  logic [bus-1:0] PCi,
    input  logic           WE,
    input  logic           RE,
    output logic [bus-1:0] StrReg,
    output logic [bus-1:0] RSd,
    output logic [bus-1:0] RXd,
    output logic [bus-1:0] RKd,
    output logic [bus-1:0] PCo
);

    logic [bus-1:0] w_rs_raw, w_rx_raw, w_rk_raw, w_str_raw;
    logic [bus-1:0] w_rsd_d, w_rxd_d, w_rkd_d, w_str_d;
    logic [bus-1:0] r_rsd_q, r_rxd_q, r_rkd_q, r_str_q, r_pc_q;

    regbank_storage #(
        .bus     (bus),
        .dir     (dir),
        .reg_num (reg_num)
    ) u_storage (
        .clk   (clk),
        .rst   (rst),
        .i_we  (WE),
        .i_wa  (RD),
        .i_wd  (WB),
        .i_ra0 (RS),
        .i_ra1 (RX),
        .i_ra2 (RK),
        .i_ra3 (RD),
        .o_rd0 (w_rs_raw),
        .o_rd1 (w_rx_raw),
        .o_rd2 (w_rk_raw),
        .o_rd3 (w_str_raw)
    );

    // Source operands are write-first; store data is read-first (pre-write value).
    always_comb begin
        w_rsd_d = r_rsd_q;
        w_rxd_d = r_rxd_q;
        w_rkd_d = r_rkd_q;
        w_str_d = r_str_q;
        if (RE) begin
            w_rsd_d = (WE && (RS == RD)) ? WB : w_rs_raw;
            w_rxd_d = (WE && (RX == RD)) ? WB : w_rx_raw;
            w_rkd_d = (WE && (RK == RD)) ? WB : w_rk_raw;
            w_str_d = w_str_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsd_q <= '0;
            r_rxd_q <= '0;
            r_rkd_q <= '0;
            r_str_q <= '0;
            r_pc_q  <= '0;
        end else begin
            r_rsd_q <= w_rsd_d;
            r_rxd_q <= w_rxd_d;
            r_rkd_q <= w_rkd_d;
            r_str_q <= w_str_d;
            r_pc_q  <= PCi;
        end
    end

    assign RSd    = r_rsd_q;
    assign RXd    = r_rxd_q;
    assign RKd    = r_rkd_q;
    assign StrReg = r_str_q;
    assign PCo    = r_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_register_bank.sv
//------------------------------------------------------------------------------
// Module   : tb_register_bank
// Brief    : Directed self-checking bench for register_bank.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_register_bank;
    import regbank_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  RD, RS, RX, RK;
    word_t       WB, PCi;
    logic        WE, RE;
    word_t       StrReg, RSd, RXd, RKd, PCo;

    int checks = 0;
    int errors = 0;

    register_bank dut (
        .clk    (clk),
        .rst    (rst),
        .RD     (RD),
        .RS     (RS),
        .RX     (RX),
        .RK     (RK),
        .WB     (WB),
        .PCi    (PCi),
        .WE     (WE),
        .RE     (RE),
        .StrReg (StrReg),
        .RSd    (RSd),
        .RXd    (RXd),
        .RKd    (RKd),
        .PCo    (PCo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t got, input word_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are then stable for checking and new drive.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        word_t exp_v;
        rst = 1'b1; WE = 1'b0; RE = 1'b0;
        RD = '0; RS = '0; RX = '0; RK = '0; WB = '0; PCi = '0;
        step();

        // Preload R[3] and confirm it is readable before the reset test
        rst = 1'b0; WE = 1'b1; RD = 4'd3; WB = 32'h0000_1234;
        step();
        WE = 1'b0; RE = 1'b1; RS = 4'd3;
        step();
        check("preload_r3", RSd, 32'h0000_1234);

        // Reset overrides WE/RE and clears everything
        rst = 1'b1; WE = 1'b1; RE = 1'b1; RD = 4'd3; WB = 32'hFFFF_FFFF; PCi = 32'h100;
        step();
        check("rst_rsd", RSd, 32'h0);
        check("rst_rxd", RXd, 32'h0);
        check("rst_rkd", RKd, 32'h0);
        check("rst_str", StrReg, 32'h0);
        check("rst_pco", PCo, 32'h0);

        rst = 1'b0; WE = 1'b0; RE = 1'b1; RS = 4'd3; RD = 4'd3; PCi = 32'h200;
        step();
        check("post_rst_r3", RSd, 32'h0);
        check("post_rst_str", StrReg, 32'h0);
        check("post_rst_pco", PCo, 32'h200);

        // Write then read; outputs hold while RE=0
        WE = 1'b1; RE = 1'b0; RD = 4'd5; WB = 32'hDEAD_BEEF;
        step();
        check("hold_during_write", RSd, 32'h0);
        WE = 1'b0; RE = 1'b1; RS = 4'd5;
        step();
        check("write_read_r5", RSd, 32'hDEAD_BEEF);

        // Bypass: sources write-first, store data read-first
        WE = 1'b1; RE = 1'b0; RD = 4'd7; WB = 32'h11;
        step();
        WE = 1'b1; RE = 1'b1; RD = 4'd7; WB = 32'h22; RS = 4'd7; RX = 4'd7; RK = 4'd7;
        step();
        check("byp_rsd", RSd, 32'h22);
        check("byp_rxd", RXd, 32'h22);
        check("byp_rkd", RKd, 32'h22);
        check("byp_str", StrReg, 32'h11);
        WE = 1'b0;
        step();
        check("after_byp_str", StrReg, 32'h22);
        check("after_byp_rsd", RSd, 32'h22);

        // Bypass only on matching addresses
        WE = 1'b1; RE = 1'b1; RD = 4'd7; WB = 32'h33; RS = 4'd5; RX = 4'd7; RK = 4'd3;
        step();
        check("mixed_rsd", RSd, 32'hDEAD_BEEF);
        check("mixed_rxd", RXd, 32'h33);
        check("mixed_rkd", RKd, 32'h0);
        check("mixed_str", StrReg, 32'h22);

        // Hold behaviour of RKd across a write to its address
        WE = 1'b1; RE = 1'b0; RD = 4'd9; WB = 32'hAA;
        step();
        WE = 1'b0; RE = 1'b1; RK = 4'd9;
        step();
        check("hold_load_aa", RKd, 32'hAA);
        WE = 1'b1; RE = 1'b0; RD = 4'd9; WB = 32'hBB;
        step();
        check("hold_rk_1", RKd, 32'hAA);
        WE = 1'b0;
        step();
        check("hold_rk_2", RKd, 32'hAA);
        RE = 1'b1;
        step();
        check("hold_release", RKd, 32'hBB);

        // PC pipe
        WE = 1'b0; RE = 1'b0;
        PCi = 32'h0;
        step();
        check("pc_0", PCo, 32'h0);
        PCi = 32'h4;
        step();
        check("pc_4", PCo, 32'h4);
        PCi = 32'h8;
        step();
        check("pc_8", PCo, 32'h8);

        // Fill and read back every register through all four ports
        WE = 1'b1; RE = 1'b0;
        for (int i = 0; i < 16; i++) begin
            RD = 4'(i);
            WB = 32'(i) * 32'h0101_0101;
            step();
        end
        WE = 1'b0; RE = 1'b1;
        for (int i = 0; i < 16; i++) begin
            RS = 4'(i);
            RX = 4'((i + 1) % 16);
            RK = 4'((i + 2) % 16);
            RD = 4'((i + 3) % 16);
            step();
            exp_v = 32'(i) * 32'h0101_0101;
            check($sformatf("all_rs_%0d", i), RSd, exp_v);
            exp_v = 32'((i + 1) % 16) * 32'h0101_0101;
            check($sformatf("all_rx_%0d", i), RXd, exp_v);
            exp_v = 32'((i + 2) % 16) * 32'h0101_0101;
            check($sformatf("all_rk_%0d", i), RKd, exp_v);
            exp_v = 32'((i + 3) % 16) * 32'h0101_0101;
            check($sformatf("all_str_%0d", i), StrReg, exp_v);
        end
        RS = 4'd15;
        step();
        check("r15_value", RSd, 32'h0F0F_0F0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
